// File: rtl/ddr_sram_arbiter.sv
// ddr_sram_arbiter: shares the DDR controller's SRAM-style request port between
// a high-priority port A and a low-priority port B, with a starvation boost for B
// and in-order routing of returned read data to the port that issued each read.
//   int_clock, int_reset            : clock, synchronous active-high reset
//   a_* / b_*                       : requester ports (req/write/address/data/be in,
//                                     ack, read_data_valid, read_data out)
//   sram_priority/read/write/...    : command toward the controller
//   sram_read_data                  : read data, READ_LATENCY cycles after issue
//   sram_low_priority_wait          : controller refuses a low-priority command
module ddr_sram_arbiter #(
    parameter int ADDR_WIDTH   = 24,
    parameter int READ_LATENCY = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  int_clock,
    input  logic                  int_reset,
    input  logic                  a_req,
    input  logic                  a_write,
    input  logic [ADDR_WIDTH-1:0] a_address,
    input  logic [31:0]           a_write_data,
    input  logic [3:0]            a_byte_enables,
    output logic                  a_ack,
    output logic                  a_read_data_valid,
    output logic [31:0]           a_read_data,
    input  logic                  b_req,
    input  logic                  b_write,
    input  logic [ADDR_WIDTH-1:0] b_address,
    input  logic [31:0]           b_write_data,
    input  logic [3:0]            b_byte_enables,
    output logic                  b_ack,
    output logic                  b_read_data_valid,
    output logic [31:0]           b_read_data,
    output logic                  sram_priority,
    output logic                  sram_read,
    output logic                  sram_write,
    output logic [ADDR_WIDTH-1:0] sram_address,
    output logic [31:0]           sram_write_data,
    output logic [3:0]            sram_write_byte_enables,
    input  logic [31:0]           sram_read_data,
    input  logic                  sram_low_priority_wait
);
    logic [7:0]              starve_count;
    logic                    boost, sel_b, issuing, write_sel, tag_in;
    logic [READ_LATENCY-1:0] tag_v, tag_p;

    always_comb begin
        boost         = b_req && (starve_count == 8'(STARVE_LIMIT));
        // B owns the port when boosted, or when it is the only requester
        sel_b         = boost || (b_req && !a_req);
        issuing       = !int_reset && (a_req || b_req);
        write_sel     = sel_b ? b_write : a_write;
        a_ack         = !int_reset && a_req && !boost;
        // only an unboosted B command can be refused by the controller
        b_ack         = !int_reset && sel_b && (boost || !sram_low_priority_wait);
        sram_priority = issuing && (boost || a_req);
        sram_read     = issuing && !write_sel;
        sram_write    = issuing && write_sel;
        sram_address            = sel_b ? b_address : a_address;
        sram_write_data         = sel_b ? b_write_data : a_write_data;
        sram_write_byte_enables = sel_b ? b_byte_enables : a_byte_enables;
        tag_in        = sram_read && (a_ack || b_ack);
    end

    always_ff @(posedge int_clock) begin
        if (int_reset) begin
            starve_count      <= 8'd0;
            tag_v             <= '0;
            tag_p             <= '0;
            a_read_data_valid <= 1'b0;
            b_read_data_valid <= 1'b0;
            a_read_data       <= 32'd0;
            b_read_data       <= 32'd0;
        end else begin
            starve_count <= (!b_req || b_ack) ? 8'd0 :
                            (starve_count == 8'(STARVE_LIMIT)) ? starve_count : starve_count + 8'd1;
            tag_v[0] <= tag_in;
            tag_p[0] <= b_ack;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_p[i] <= tag_p[i-1];
            end
            // last stage lines up with the controller's data for that read
            a_read_data_valid <= tag_v[READ_LATENCY-1] && !tag_p[READ_LATENCY-1];
            b_read_data_valid <= tag_v[READ_LATENCY-1] && tag_p[READ_LATENCY-1];
            if (tag_v[READ_LATENCY-1] && !tag_p[READ_LATENCY-1]) a_read_data <= sram_read_data;
            if (tag_v[READ_LATENCY-1] && tag_p[READ_LATENCY-1]) b_read_data <= sram_read_data;
        end
    end
endmodule

// File: tb/tb_ddr_sram_arbiter.sv
// tb_ddr_sram_arbiter: randomized and directed scoreboard bench for ddr_sram_arbiter.
module tb_ddr_sram_arbiter;
    localparam int AW = 24;
    localparam int L  = 2;
    localparam int SL = 8;

    logic clk = 0, rst = 1;
    logic a_req = 0, a_write = 0, b_req = 0, b_write = 0, wait_in = 0;
    logic [AW-1:0] a_addr = 0, b_addr = 0;
    logic [31:0] a_wd = 0, b_wd = 0, sram_read_data = 0;
    logic [3:0] a_be = 0, b_be = 0;
    logic a_ack, b_ack, a_rv, b_rv, sram_priority, sram_read, sram_write;
    logic [31:0] a_rd, b_rd, sram_write_data;
    logic [AW-1:0] sram_address;
    logic [3:0] sram_be;

    ddr_sram_arbiter #(.ADDR_WIDTH(AW), .READ_LATENCY(L), .STARVE_LIMIT(SL)) dut (
        .int_clock(clk), .int_reset(rst),
        .a_req(a_req), .a_write(a_write), .a_address(a_addr), .a_write_data(a_wd),
        .a_byte_enables(a_be), .a_ack(a_ack), .a_read_data_valid(a_rv), .a_read_data(a_rd),
        .b_req(b_req), .b_write(b_write), .b_address(b_addr), .b_write_data(b_wd),
        .b_byte_enables(b_be), .b_ack(b_ack), .b_read_data_valid(b_rv), .b_read_data(b_rd),
        .sram_priority(sram_priority), .sram_read(sram_read), .sram_write(sram_write),
        .sram_address(sram_address), .sram_write_data(sram_write_data),
        .sram_write_byte_enables(sram_be), .sram_read_data(sram_read_data),
        .sram_low_priority_wait(wait_in)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; int c; } ret_t;
    ret_t qa[$], qb[$];
    logic [31:0] ret_data [int];
    int checks = 0, errors = 0, cyc = 0, waited = 0;
    logic exp_a_ack = 0, exp_b_ack = 0, seen_a_ack = 0, seen_b_ack = 0, mon_on = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One bus cycle: the reference decides who should own the port from the
    // priority rules and how long B has been kept waiting, then checks the DUT.
    task automatic step(input logic [31:0] rdata);
        logic boost, own_b, ga, gb, busy, wr, hi;
        sram_read_data = ret_data.exists(cyc) ? ret_data[cyc] : $urandom;
        @(negedge clk);
        boost = b_req && waited >= SL;
        busy = !rst && (a_req || b_req);
        ga = 0; gb = 0; own_b = 0; hi = 0;
        if (boost) begin own_b = 1; hi = 1; gb = !rst; end
        else if (a_req) begin hi = 1; ga = !rst; end
        else if (b_req) begin own_b = 1; gb = !rst && !wait_in; end
        wr = own_b ? b_write : a_write;
        exp_a_ack = ga; exp_b_ack = gb;
        seen_a_ack = a_ack; seen_b_ack = b_ack;
        chk("ctl{a_ack,b_ack,rd,wr,prio}", 64'({a_ack, b_ack, sram_read, sram_write, sram_priority}),
            64'({ga, gb, busy && !wr, busy && wr, busy && hi}));
        if (!rst)
            chk("cmd{addr,data,be}", 64'({sram_address, sram_write_data, sram_be}),
                own_b ? 64'({b_addr, b_wd, b_be}) : 64'({a_addr, a_wd, a_be}));
        if ((ga || gb) && !wr) begin
            ret_data[cyc + L] = rdata;
            if (ga) qa.push_back('{rdata, cyc + L + 1});
            else qb.push_back('{rdata, cyc + L + 1});
        end
        if (rst) begin
            while (qa.size() > 0 && qa[$].c > cyc) void'(qa.pop_back());
            while (qb.size() > 0 && qb[$].c > cyc) void'(qb.pop_back());
        end
        waited = (rst || !b_req || gb) ? 0 : (waited < SL ? waited + 1 : waited);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            logic ea, eb;
            ret_t e;
            ea = qa.size() > 0 && qa[0].c == cyc;
            eb = qb.size() > 0 && qb[0].c == cyc;
            chk("a_read_data_valid", 64'(a_rv), 64'(ea));
            chk("b_read_data_valid", 64'(b_rv), 64'(eb));
            if (ea) begin e = qa.pop_front(); if (a_rv) chk("a_read_data", 64'(a_rd), 64'(e.d)); end
            if (eb) begin e = qb.pop_front(); if (b_rv) chk("b_read_data", 64'(b_rd), 64'(e.d)); end
        end
    end

    initial begin
        int b_at, a_off;
        @(posedge clk);
        #1;
        mon_on = 1;
        // reset held with both ports requesting
        a_req = 1; b_req = 1;
        repeat (3) step($urandom);
        rst = 0; a_req = 0; b_req = 0;
        step(0);
        // single port A read
        a_req = 1; a_write = 0; a_addr = 24'h000010;
        step(32'hDEADBEEF);
        chk("a_read_ack", 64'(seen_a_ack), 64'(1));
        a_req = 0;
        repeat (4) step(0);
        // B write held off by the controller for four cycles
        b_req = 1; b_write = 1; b_addr = 24'h123456; b_be = 4'h5; b_wd = $urandom;
        b_at = -1;
        for (int i = 1; i <= 5; i++) begin
            wait_in = (i < 5);
            step(0);
            if (seen_b_ack && b_at < 0) b_at = i;
        end
        chk("b_wait_ack_cycle", 64'(b_at), 64'(5));
        b_req = 0; wait_in = 0;
        step(0);
        // starvation boost with A requesting continuously
        a_req = 1; a_write = 1; b_req = 1; b_write = 0; b_addr = $urandom;
        b_at = -1; a_off = -1;
        for (int i = 0; i < 11; i++) begin
            a_addr = $urandom; a_wd = $urandom;
            step($urandom);
            if (seen_b_ack && b_at < 0) begin b_at = i; b_req = 0; end
            if (!seen_a_ack && a_off < 0) a_off = i;
        end
        chk("starve_b_ack_cycle", 64'(b_at), 64'(SL));
        chk("starve_a_held_cycle", 64'(a_off), 64'(SL));
        a_req = 0;
        repeat (4) step(0);
        // interleaved A/B reads returning 1..4
        a_write = 0; b_write = 0;
        for (int k = 0; k < 4; k++) begin
            a_req = (k % 2 == 0); b_req = (k % 2 == 1);
            a_addr = $urandom; b_addr = $urandom;
            step(32'(k + 1));
        end
        a_req = 0; b_req = 0;
        repeat (5) step(0);
        // reset one cycle after two accepted reads
        a_req = 1; step($urandom);
        a_req = 0; b_req = 1; step($urandom);
        b_req = 0; rst = 1; step(0);
        rst = 0; step(0);
        a_req = 1; a_addr = $urandom; step(32'hA5A55A5A);
        a_req = 0;
        repeat (5) step(0);
        // random traffic honouring hold-until-ack
        for (int n = 0; n < 400; n++) begin
            if (!a_req && ($urandom % 100) < 80) begin
                a_req = 1; a_write = $urandom; a_addr = $urandom; a_wd = $urandom; a_be = $urandom;
            end
            if (!b_req && ($urandom % 2) == 0) begin
                b_req = 1; b_write = $urandom; b_addr = $urandom; b_wd = $urandom; b_be = $urandom;
            end
            wait_in = ($urandom % 3) == 0;
            rst = ($urandom % 60) == 0;
            step($urandom);
            if (exp_a_ack) a_req = 0;
            if (exp_b_ack) b_req = 0;
        end
        a_req = 0; b_req = 0; rst = 0; wait_in = 0;
        repeat (6) step(0);
        chk("a_returns_drained", 64'(qa.size()), 64'(0));
        chk("b_returns_drained", 64'(qb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
